// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data access; data wins unless fetch has starved.
// Optional ARB_PERF_CNT_EN adds saturating conflict/starvation counters.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int STREAK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic          dm_byte,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic          mem_byte,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          fetch_stall
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]   perf_conflict,
  output logic [15:0]   perf_starve
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM
  } state_t;

  localparam logic [3:0] SMAX = 4'(STREAK_MAX);

  state_t     state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       starved;
  logic       dm_win;

  assign starved     = (streak_q == SMAX);
  assign dm_win      = dm_req & ~(if_req & starved);
  assign fetch_stall = if_req & ~if_gnt;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_win) begin
          dm_gnt  = 1'b1;
          state_d = BUSY_DM;
        end else if (if_req) begin
          if_gnt  = 1'b1;
          state_d = BUSY_IF;
        end
        if (dm_win & if_req)
          streak_d = starved ? SMAX : streak_q + 4'd1;
        else
          streak_d = 4'd0;
      end
      BUSY_IF: if (mem_ready) state_d = IDLE;
      BUSY_DM: if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A grant during reset would be dropped, so never show one.
    if (!rst_n) begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      streak_q  <= 4'd0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_byte  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if_valid <= (state_q == BUSY_IF) & mem_ready;
      dm_valid <= (state_q == BUSY_DM) & mem_ready;
      if ((state_q == BUSY_IF) & mem_ready)
        if_rdata <= mem_rdata;
      if ((state_q == BUSY_DM) & mem_ready & ~mem_we)
        dm_rdata <= mem_rdata;
      if (dm_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_byte  <= dm_byte;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (if_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_byte  <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end else if (mem_ready) begin
        mem_req   <= 1'b0;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  // A fetch grant with data also pending can only come from the streak limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_conflict <= '0;
      perf_starve   <= '0;
    end else begin
      if ((state_q == IDLE) & if_req & dm_req & (perf_conflict != 16'hFFFF))
        perf_conflict <= perf_conflict + 16'd1;
      if (if_gnt & dm_req & (perf_starve != 16'hFFFF))
        perf_starve <= perf_starve + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
// Define ARB_PERF_CNT_EN to also check the performance counters.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_gnt, if_valid;
  logic [15:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0, dm_byte = 1'b0;
  logic [15:0] dm_addr = '0, dm_wdata = '0;
  logic        dm_gnt, dm_valid;
  logic [15:0] dm_rdata;
  logic        mem_req, mem_we, mem_byte;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        fetch_stall;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_conflict, perf_starve;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(16), .DW(16), .STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .fetch_stall(fetch_stall)
`ifdef ARB_PERF_CNT_EN
    , .perf_conflict(perf_conflict), .perf_starve(perf_starve)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 fetch, 2 data)
  int          m_own, m_streak, m_conf, m_starve;
  logic [15:0] m_addr, m_wdata, m_ifr, m_dmr;
  logic        m_we, m_byte, m_ifv, m_dmv;
  int          glog[$];
  bit          e_ifg, e_dmg;

  // Stimulus controls
  bit          rst_v = 1'b0, manual = 1'b1, rd_fix = 1'b0;
  bit          if_on = 1'b0, dm_on = 1'b0;
  int          p_if = 0, p_dm = 0, p_rdy = 100;
  logic [15:0] rd_val = '0;

  task automatic model_reset();
    m_own = 0; m_streak = 0; m_conf = 0; m_starve = 0;
    m_ifv = 0; m_dmv = 0; m_ifr = '0; m_dmr = '0;
    m_addr = '0; m_wdata = '0; m_we = 0; m_byte = 0;
    e_ifg = 0; e_dmg = 0;
  endtask

  task automatic cycle();
    bit dwin;
    @(posedge clk);
    #1;
    rst_n = rst_v;
    if (e_ifg) if_on = 0;
    if (e_dmg) dm_on = 0;
    if (!manual) begin
      if (!if_on && $urandom_range(99) < p_if) begin
        if_on = 1;
        if_addr = 16'($urandom) & 16'hFFFE;
      end
      if (!dm_on && $urandom_range(99) < p_dm) begin
        dm_on = 1;
        dm_we = 1'($urandom_range(1));
        dm_byte = 1'($urandom_range(1));
        dm_addr = 16'($urandom);
        dm_wdata = 16'($urandom);
      end
    end
    if_req = if_on;
    dm_req = dm_on;
    mem_ready = $urandom_range(99) < p_rdy;
    mem_rdata = rd_fix ? rd_val : 16'($urandom);
    @(negedge clk);
    dwin  = dm_req && !(if_req && m_streak == SMAX);
    e_dmg = rst_v && m_own == 0 && dwin;
    e_ifg = rst_v && m_own == 0 && if_req && !dwin;
    check("if_gnt", if_gnt, e_ifg);
    check("dm_gnt", dm_gnt, e_dmg);
    check("fetch_stall", fetch_stall, if_req && !e_ifg);
    check("mem_req", mem_req, m_own != 0);
    if (m_own != 0) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_we", mem_we, m_we);
      check("mem_byte", mem_byte, m_byte);
      if (m_own == 2) check("mem_wdata", mem_wdata, m_wdata);
    end
    check("if_valid", if_valid, m_ifv);
    check("dm_valid", dm_valid, m_dmv);
    check("if_rdata", if_rdata, m_ifr);
    check("dm_rdata", dm_rdata, m_dmr);
`ifdef ARB_PERF_CNT_EN
    check("perf_conflict", perf_conflict, m_conf);
    check("perf_starve", perf_starve, m_starve);
`endif
    if (!rst_v) begin
      model_reset();
    end else begin
      m_ifv = 0;
      m_dmv = 0;
      if (m_own == 1 && mem_ready) begin
        m_ifv = 1; m_ifr = mem_rdata; m_own = 0;
      end else if (m_own == 2 && mem_ready) begin
        m_dmv = 1;
        if (!m_we) m_dmr = mem_rdata;
        m_own = 0;
      end else if (m_own == 0) begin
        if (if_req && dm_req && m_conf < 65535) m_conf++;
        if (e_dmg) begin
          m_own = 2; m_we = dm_we; m_byte = dm_byte;
          m_addr = dm_addr; m_wdata = dm_wdata;
          glog.push_back(2);
          m_streak = if_req ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
        end else if (e_ifg) begin
          m_own = 1; m_we = 0; m_byte = 0; m_addr = if_addr;
          glog.push_back(1);
          if (dm_req && m_starve < 65535) m_starve++;
          m_streak = 0;
        end else begin
          m_streak = 0;
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (if_on || dm_on || m_own != 0); i++)
      cycle();
    check("drain_done", (if_on || dm_on || m_own != 0), 0);
  endtask

  int n, vcnt;
  logic [15:0] saved;

  initial begin
    model_reset();
    repeat (2) cycle();
    rst_v = 1;
    cycle();

    // Lone fetch
    if_on = 1; if_addr = 16'h0100; rd_fix = 1; rd_val = 16'h1234; p_rdy = 100;
    cycle();
    check("t2_gnt", if_gnt, 1);
    cycle();
    check("t2_addr", mem_addr, 16'h0100);
    check("t2_we", mem_we, 0);
    cycle();
    check("t2_valid", if_valid, 1);
    check("t2_rdata", if_rdata, 16'h1234);
    rd_fix = 0;

    // Conflict: data first, then fetch
    glog.delete();
    if_on = 1; if_addr = 16'h0200;
    dm_on = 1; dm_we = 0; dm_byte = 0; dm_addr = 16'h0800;
    cycle();
    check("t3_dm_gnt", dm_gnt, 1);
    check("t3_stall", fetch_stall, 1);
    drain();
    check("t3_n", glog.size(), 2);
    check("t3_first", glog[0], 2);
    check("t3_second", glog[1], 1);

    // Starvation: both held continuously
    glog.delete();
    manual = 0; p_if = 100; p_dm = 100; p_rdy = 100;
    for (int i = 0; i < 200 && glog.size() < 6; i++) cycle();
    manual = 1;
    check("t4_n", glog.size() >= 6, 1);
    n = 0;
    for (int i = 0; i < 6; i++) n = n * 4 + glog[i];
    check("t4_order", n, 32'b10_10_10_10_01_10);
`ifdef ARB_PERF_CNT_EN
    check("t4_starve", perf_starve, 1);
`endif
    drain();

    // Byte write with three wait states
    saved = m_dmr;
    dm_on = 1; dm_we = 1; dm_byte = 1; dm_addr = 16'h0A03; dm_wdata = 16'h00AB;
    p_rdy = 0;
    cycle();
    n = 0; vcnt = 0;
    repeat (3) begin
      cycle();
      n += int'(mem_req);
      vcnt += int'(dm_valid);
    end
    p_rdy = 100;
    cycle();
    n += int'(mem_req);
    vcnt += int'(dm_valid);
    cycle();
    vcnt += int'(dm_valid);
    cycle();
    vcnt += int'(dm_valid);
    check("t5_busy", n, 4);
    check("t5_pulses", vcnt, 1);
    check("t5_rdata", dm_rdata, saved);

    // Reset in the middle of a stalled data access
    dm_on = 1; dm_we = 0; dm_byte = 0; dm_addr = 16'h0444;
    p_rdy = 0;
    cycle();
    cycle();
    rst_v = 0;
    cycle();
    rst_v = 1; p_rdy = 100;
    cycle();
    check("t1_memreq", mem_req, 0);
    vcnt = 0;
    repeat (4) begin
      cycle();
      vcnt += int'(dm_valid);
    end
    check("t1_no_valid", vcnt, 0);

    // Stray mem_ready while idle
    vcnt = 0;
    repeat (4) begin
      cycle();
      vcnt += int'(if_valid) + int'(dm_valid) + int'(mem_req);
    end
    check("t6_quiet", vcnt, 0);

    // Random traffic
    manual = 0; p_if = 40; p_dm = 40; p_rdy = 60;
    repeat (3000) cycle();
    p_if = 100; p_dm = 85; p_rdy = 80;
    repeat (1500) cycle();
    manual = 1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
